// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - fetch-port responder bridging to a req/gnt/rvalid instruction bus
// Defining IFETCH_PREFETCH_EN adds a second, next-line prefetch buffer entry.
module ifetch_responder #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] REBOOT_PC = '0
) (
  input  logic          ck_i,
  input  logic          rs_n_i,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic          flush_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_valid_o,
  output logic          inst_fault_o,
  output logic          stall_req_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_inst;
  logic [AW-1:0] r_inst_pc;
  logic          r_fault;
  logic          r_buf_valid;
  logic [AW-1:0] r_mem_addr;
  logic          r_stale;

  logic          w_stale_nxt;
  logic          w_prim_hit;
  logic          w_hit;
  logic          w_miss;
  logic          w_issue;
  logic [AW-1:0] w_issue_addr;
  logic          w_fill;
  logic          w_fill_prim;
  logic          w_misalign;

  assign w_prim_hit = r_buf_valid && (r_inst_pc == pc_i);

`ifdef IFETCH_PREFETCH_EN
  logic [DW-1:0] r_pf_inst;
  logic [AW-1:0] r_pf_pc;
  logic          r_pf_fault;
  logic          r_pf_valid;
  logic          r_is_pf;
  logic          w_pf_hit;
  logic          w_pf_sel;
  logic          w_pf_want;
  logic          w_promote;
  logic          w_issue_pf;
  logic [AW-1:0] w_next_pc;

  assign w_next_pc    = r_inst_pc + AW'(4);
  // A flush kills the speculative entry in the same cycle it is requested.
  assign w_pf_hit     = r_pf_valid && !flush_i && (r_pf_pc == pc_i);
  assign w_pf_sel     = w_pf_hit && !w_prim_hit;
  assign w_hit        = w_prim_hit || w_pf_hit;
  assign w_pf_want    = ce_i && !flush_i && w_prim_hit && (r_inst_pc[1:0] == 2'b00) &&
                        !(r_pf_valid && (r_pf_pc == w_next_pc));
  assign w_promote    = ce_i && w_pf_sel && !w_fill;
  assign w_fill_prim  = w_fill && !r_is_pf;
  assign inst_o       = w_pf_sel ? r_pf_inst  : r_inst;
  assign inst_pc_o    = w_pf_sel ? r_pf_pc    : r_inst_pc;
  assign inst_fault_o = w_pf_sel ? r_pf_fault : r_fault;
`else
  assign w_hit        = w_prim_hit;
  assign w_fill_prim  = w_fill;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_fault_o = r_fault;
`endif

  assign w_miss       = ce_i && !w_hit && !flush_i;
  assign stall_req_o  = w_miss;
  assign inst_valid_o = ce_i && w_hit;
  assign mem_req_o    = w_issue || (r_state == S_REQ);
  assign mem_addr_o   = w_issue ? w_issue_addr : r_mem_addr;

  always_comb begin
    w_state_nxt  = r_state;
    w_stale_nxt  = r_stale;
    w_issue      = 1'b0;
    w_issue_addr = pc_i;
    w_fill       = 1'b0;
    w_misalign   = 1'b0;
`ifdef IFETCH_PREFETCH_EN
    w_issue_pf   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_stale_nxt = 1'b0;
        if (w_miss) begin
          if (pc_i[1:0] == 2'b00) w_issue = 1'b1;
          else                    w_misalign = 1'b1;
        end
`ifdef IFETCH_PREFETCH_EN
        else if (w_pf_want) begin
          w_issue      = 1'b1;
          w_issue_pf   = 1'b1;
          w_issue_addr = w_next_pc;
        end
`endif
        // The request is visible this cycle, so a same-cycle grant skips REQ.
        if (w_issue) w_state_nxt = mem_gnt_i ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          w_state_nxt = (r_stale || flush_i) ? S_DRAIN : S_WAIT;
          w_stale_nxt = 1'b0;
        end else if (flush_i) begin
          w_stale_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rvalid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      r_state     <= S_IDLE;
      r_stale     <= 1'b0;
      r_mem_addr  <= '0;
      r_inst      <= '0;
      r_inst_pc   <= REBOOT_PC;
      r_fault     <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stale <= w_stale_nxt;
      if (w_issue) r_mem_addr <= w_issue_addr;
      if (w_fill_prim) begin
        r_inst      <= mem_rdata_i;
        r_inst_pc   <= r_mem_addr;
        r_fault     <= mem_err_i;
        r_buf_valid <= 1'b1;
      end else if (w_misalign) begin
        r_inst      <= '0;
        r_inst_pc   <= pc_i;
        r_fault     <= 1'b1;
        r_buf_valid <= 1'b1;
      end
`ifdef IFETCH_PREFETCH_EN
      else if (w_promote) begin
        r_inst    <= r_pf_inst;
        r_inst_pc <= r_pf_pc;
        r_fault   <= r_pf_fault;
      end
`endif
    end
  end

`ifdef IFETCH_PREFETCH_EN
  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      r_pf_inst  <= '0;
      r_pf_pc    <= '0;
      r_pf_fault <= 1'b0;
      r_pf_valid <= 1'b0;
      r_is_pf    <= 1'b0;
    end else begin
      if (w_issue) r_is_pf <= w_issue_pf;
      if (flush_i) begin
        r_pf_valid <= 1'b0;
      end else if (w_fill && r_is_pf) begin
        r_pf_inst  <= mem_rdata_i;
        r_pf_pc    <= r_mem_addr;
        r_pf_fault <= mem_err_i;
        r_pf_valid <= 1'b1;
      end else if (w_promote) begin
        r_pf_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// tb/tb_ifetch_responder.sv - self-checking bench for ifetch_responder with a behavioural bus model
module tb_ifetch_responder;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        ck_i = 1'b0;
  logic        rs_n_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_fault_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  ifetch_responder #(.AW(32), .DW(32), .REBOOT_PC(RESET_PC)) dut (
    .ck_i(ck_i), .rs_n_i(rs_n_i), .pc_i(pc_i), .ce_i(ce_i), .flush_i(flush_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_fault_o(inst_fault_o), .stall_req_o(stall_req_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 ck_i = ~ck_i;

  // Memory contents and error map of the bus model
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Bus slave: grant after gnt_delay request cycles, respond rv_delay cycles after grant
  int gnt_delay = 0, rv_delay = 1, req_cnt = 0, rv_cnt = 0, rv_seen = 0, proto_err = 0;
  bit outstanding = 1'b0, rand_bus = 1'b0;
  logic [31:0] rv_addr = '0, req_addr = '0;

  always @(posedge ck_i) begin
    #2;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    if (!rs_n_i) begin
      req_cnt = 0; rv_cnt = 0; outstanding = 1'b0;
    end else begin
      if (mem_req_o && outstanding) proto_err++;
      if (mem_req_o && req_cnt > 0 && mem_addr_o !== req_addr) proto_err++;
      if (outstanding) begin
        rv_cnt--;
        if (rv_cnt <= 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = mem_word(rv_addr);
          mem_err_i = (rv_addr == err_addr); outstanding = 1'b0; rv_seen++;
        end
      end
      if (mem_req_o && !outstanding) begin
        if (req_cnt == 0) req_addr = mem_addr_o;
        if (req_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1; rv_addr = mem_addr_o; rv_cnt = rv_delay; outstanding = 1'b1; req_cnt = 0;
          if (rand_bus) begin gnt_delay = $urandom_range(0, 3); rv_delay = $urandom_range(1, 3); end
        end else begin
          req_cnt++;
        end
      end
    end
  end

  task automatic cyc(); @(posedge ck_i); #1; endtask
  task automatic smp(); @(negedge ck_i); endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (inst_valid_o) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic test_reset();
    rs_n_i = 1'b1; #1 rs_n_i = 1'b0;
    repeat (2) @(posedge ck_i);
    smp();
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want %h", inst_o, 32'h0); end
    checks++; if (inst_pc_o !== RESET_PC) begin errors++; $display("FAIL reset_inst_pc got %h want %h", inst_pc_o, RESET_PC); end
    checks++; if ({inst_valid_o, inst_fault_o, stall_req_o, mem_req_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {inst_valid_o, inst_fault_o, stall_req_o, mem_req_o}); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr_o); end
    cyc();
    rs_n_i = 1'b1;
  endtask

  task automatic test_min_miss();
    gnt_delay = 0; rv_delay = 1; ce_i = 1'b1; pc_i = 32'h0;
    smp();
    checks++; if ({mem_req_o, stall_req_o, inst_valid_o, mem_addr_o} !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL min_miss_c1 got %b/%h want 110/0", {mem_req_o, stall_req_o, inst_valid_o}, mem_addr_o); end
    cyc(); smp();
    checks++; if ({mem_req_o, stall_req_o, inst_valid_o} !== 3'b010) begin
      errors++; $display("FAIL min_miss_c2 got %b want 010", {mem_req_o, stall_req_o, inst_valid_o}); end
    cyc(); smp();
    checks++; if ({mem_req_o, stall_req_o, inst_valid_o} !== 3'b001) begin
      errors++; $display("FAIL min_miss_c3 got %b want 001", {mem_req_o, stall_req_o, inst_valid_o}); end
    checks++; if ({inst_o, inst_pc_o, inst_fault_o} !== {32'h0000_0013, 32'h0, 1'b0}) begin
      errors++; $display("FAIL min_miss_data got %h/%h/%b want 00000013/0/0", inst_o, inst_pc_o, inst_fault_o); end
    cyc();
  endtask

  task automatic test_hold_hit();
    for (int i = 0; i < 5; i++) begin
      smp();
      checks++; if ({mem_req_o, stall_req_o, inst_valid_o, inst_o} !== {3'b001, 32'h0000_0013}) begin
        errors++; $display("FAIL hold_hit cyc %0d got %b/%h want 001/00000013", i, {mem_req_o, stall_req_o, inst_valid_o}, inst_o); end
      cyc();
    end
  endtask

  task automatic test_delayed_grant();
    bit ok;
    int n;
    gnt_delay = 3; rv_delay = 2; pc_i = 32'h104;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++; if ({mem_req_o, stall_req_o, mem_addr_o} !== {2'b11, 32'h104}) begin
        errors++; $display("FAIL dgrant_req cyc %0d got %b/%h want 11/00000104", i, {mem_req_o, stall_req_o}, mem_addr_o); end
      cyc();
    end
    n = 0; smp();
    while (!inst_valid_o && n < 20) begin
      checks++; if ({mem_req_o, stall_req_o} !== 2'b01) begin
        errors++; $display("FAIL dgrant_wait got %b want 01", {mem_req_o, stall_req_o}); end
      cyc(); smp(); n++;
    end
    ok = inst_valid_o;
    checks++; if (!ok) begin errors++; $display("FAIL dgrant_timeout got valid 0 want 1"); end
    checks++; if ({inst_o, inst_pc_o, inst_fault_o} !== {mem_word(32'h104), 32'h104, 1'b0}) begin
      errors++; $display("FAIL dgrant_data got %h/%h want %h/00000104", inst_o, inst_pc_o, mem_word(32'h104)); end
    cyc();
  endtask

  task automatic test_flush_drain();
    bit ok;
    int n, seen0;
    gnt_delay = 0; rv_delay = 4; pc_i = 32'h200;
    smp();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL flush_req got %b/%h want 1/00000200", mem_req_o, mem_addr_o); end
    cyc(); flush_i = 1'b1; smp();
    checks++; if ({mem_req_o, stall_req_o} !== 2'b00) begin
      errors++; $display("FAIL flush_stall got %b want 00", {mem_req_o, stall_req_o}); end
    cyc(); flush_i = 1'b0; pc_i = 32'h80; seen0 = rv_seen;
    n = 0; smp();
    while (!mem_req_o && n < 20) begin
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL flush_drain_stall got 0 want 1"); end
      cyc(); smp(); n++;
    end
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h80} || rv_seen != seen0 + 1) begin
      errors++; $display("FAIL flush_reissue got req %b addr %h rsp %0d want 1/00000080/%0d", mem_req_o, mem_addr_o, rv_seen - seen0, 1); end
    checks++; if (inst_pc_o !== 32'h104) begin
      errors++; $display("FAIL flush_discard got %h want 00000104", inst_pc_o); end
    wait_valid(ok);
    checks++; if (!ok || {inst_o, inst_pc_o} !== {mem_word(32'h80), 32'h80}) begin
      errors++; $display("FAIL flush_refetch got %b/%h/%h want 1/%h/00000080", ok, inst_o, inst_pc_o, mem_word(32'h80)); end
    cyc();
  endtask

  task automatic test_flush_in_req();
    bit ok;
    gnt_delay = 2; rv_delay = 1; pc_i = 32'h300;
    smp();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL freq_c1 got %b want 1", mem_req_o); end
    cyc(); flush_i = 1'b1; smp();
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL freq_hold got %b/%h want 1/00000300", mem_req_o, mem_addr_o); end
    cyc(); flush_i = 1'b0; smp();
    checks++; if ({mem_req_o, stall_req_o} !== 2'b11) begin
      errors++; $display("FAIL freq_grant got %b want 11", {mem_req_o, stall_req_o}); end
    cyc(); smp();
    checks++; if ({mem_req_o, stall_req_o} !== 2'b01) begin
      errors++; $display("FAIL freq_drain got %b want 01", {mem_req_o, stall_req_o}); end
    cyc(); smp();
    checks++; if ({mem_req_o, inst_valid_o} !== 2'b10) begin
      errors++; $display("FAIL freq_refetch got %b want 10", {mem_req_o, inst_valid_o}); end
    wait_valid(ok);
    checks++; if (!ok || inst_o !== mem_word(32'h300)) begin
      errors++; $display("FAIL freq_data got %b/%h want 1/%h", ok, inst_o, mem_word(32'h300)); end
    cyc(); flush_i = 1'b1; smp();
    checks++; if ({inst_valid_o, stall_req_o, mem_req_o} !== 3'b100) begin
      errors++; $display("FAIL flush_keep got %b want 100", {inst_valid_o, stall_req_o, mem_req_o}); end
    cyc(); flush_i = 1'b0; smp();
    checks++; if ({inst_valid_o, stall_req_o, mem_req_o} !== 3'b100) begin
      errors++; $display("FAIL flush_after got %b want 100", {inst_valid_o, stall_req_o, mem_req_o}); end
    cyc();
  endtask

  task automatic test_misaligned();
    pc_i = 32'h102;
    smp();
    checks++; if ({mem_req_o, stall_req_o, inst_valid_o} !== 3'b010) begin
      errors++; $display("FAIL misalign_c1 got %b want 010", {mem_req_o, stall_req_o, inst_valid_o}); end
    cyc(); smp();
    checks++; if ({mem_req_o, inst_valid_o, stall_req_o, inst_fault_o, inst_pc_o, inst_o} !== {4'b0101, 32'h102, 32'h0}) begin
      errors++; $display("FAIL misalign_c2 got %b/%h/%h want 0101/00000102/0",
                         {mem_req_o, inst_valid_o, stall_req_o, inst_fault_o}, inst_pc_o, inst_o); end
    cyc();
  endtask

  task automatic test_bus_error();
    bit ok;
    gnt_delay = 0; rv_delay = 1; err_addr = 32'h40; pc_i = 32'h40;
    wait_valid(ok);
    checks++; if (!ok || {inst_fault_o, inst_valid_o, stall_req_o, inst_pc_o} !== {3'b110, 32'h40}) begin
      errors++; $display("FAIL bus_error got %b/%b/%b/%h want 1/1/0/00000040", ok, inst_fault_o, stall_req_o, inst_pc_o); end
    cyc();
  endtask

  task automatic test_random();
    logic [31:0] pcs [0:7];
    logic [31:0] exp_i;
    bit ok, exp_f, last_stall;
    int stall_run;
    pcs = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h104, 32'h200, 32'h102, 32'h3FC};
    rand_bus = 1'b1; stall_run = 0; last_stall = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!last_stall && $urandom_range(0, 1) == 0) pc_i = pcs[$urandom_range(0, 7)];
      ce_i = ($urandom_range(0, 7) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      smp();
      if (!ce_i)        ok = !stall_req_o && !inst_valid_o;
      else if (flush_i) ok = !stall_req_o;
      else              ok = (stall_req_o != inst_valid_o);
      checks++; if (!ok) begin
        errors++; $display("FAIL rand_handshake cyc %0d ce %b fl %b got stall %b valid %b", c, ce_i, flush_i, stall_req_o, inst_valid_o); end
      if (inst_valid_o) begin
        exp_f = (pc_i[1:0] != 2'b00) || (pc_i == err_addr);
        exp_i = (pc_i[1:0] != 2'b00) ? 32'h0 : mem_word(pc_i);
        checks++; if ({inst_pc_o, inst_o, inst_fault_o} !== {pc_i, exp_i, exp_f}) begin
          errors++; $display("FAIL rand_data cyc %0d got %h/%h/%b want %h/%h/%b", c, inst_pc_o, inst_o, inst_fault_o, pc_i, exp_i, exp_f); end
      end
      stall_run = stall_req_o ? stall_run + 1 : 0;
      checks++; if (stall_run > 40) begin
        errors++; $display("FAIL rand_progress cyc %0d got stall run %0d want <= 40", c, stall_run); stall_run = 0; end
      last_stall = stall_req_o;
      cyc();
    end
    rand_bus = 1'b0;
    checks++; if (proto_err != 0) begin errors++; $display("FAIL bus_protocol got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_min_miss();
    test_hold_hit();
    test_delayed_grant();
    test_flush_drain();
    test_flush_in_req();
    test_misaligned();
    test_bus_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
